// File: rtl/inst_loader.sv
// inst_loader: byte-stream program loader for the instruction memory.
// Takes a little-endian image (4-byte word count N, then N words LSB first)
// over a valid/ready byte handshake and writes one 32-bit instruction per
// WRITE cycle, keeping cpu_hold asserted until the image is in place.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds a trailing 32-bit
// checksum (sum of all words mod 2^32) verified in the CHK state.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, no load active, core released
// HDR     | collecting the 4 header bytes (word count N)
// DATA    | collecting the 4 bytes of the next instruction
// WRITE   | single-cycle write strobe into instruction memory
// CHK     | collecting the 4 checksum bytes (checksum build only)
// DONE    | image loaded, core released
// ERR     | header overflow or checksum mismatch, core held

`ifndef WORD
`define WORD 32
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

module inst_loader #(
  parameter int unsigned      SIZE      = 1024,
  parameter logic [`WORD-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   wr_en,
  output logic [`WORD-1:0]       wr_addr,
  output logic [`INST_SIZE-1:0]  wr_data,
  output logic [$clog2(SIZE):0]  word_cnt,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   overflow,
  output logic                   chk_err
);

  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [31:0]            hdr_q, hdr_d;
  logic [31:0]            shift_q, shift_d;
  logic [CW-1:0]          word_cnt_q, word_cnt_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [`WORD-1:0]       wr_addr_q, wr_addr_d;
  logic [`INST_SIZE-1:0]  wr_data_q, wr_data_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]            sum_q, sum_d;
  logic [31:0]            chk_q, chk_d;
  logic                   chk_err_q, chk_err_d;
`endif

  logic                   accept;
  logic [4:0]             byte_pos;
  logic [31:0]            n_full;
  logic                   finish_load;
  logic                   start_ok;

  assign accept   = rx_valid && rx_ready_q;
  assign byte_pos = {byte_cnt_q, 3'b000};
  assign n_full   = {rx_data, hdr_q[23:0]};
  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  // Next-state and next-output logic; every register holds unless a case below moves it.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    hdr_d       = hdr_q;
    shift_d     = shift_q;
    word_cnt_d  = word_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    finish_load = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    chk_d       = chk_q;
    chk_err_d   = chk_err_q;
`endif

    if (start_ok) begin
      state_d    = S_HDR;
      cpu_hold_d = 1'b1;
      done_d     = 1'b0;
      overflow_d = 1'b0;
      word_cnt_d = '0;
      byte_cnt_d = 2'd0;
      hdr_d      = '0;
`ifdef INST_LOADER_CHECKSUM_EN
      chk_err_d  = 1'b0;
      sum_d      = '0;
`endif
    end else begin
      case (state_q)
        S_HDR: begin
          if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            hdr_d[byte_pos +: 8] = rx_data;
            if (byte_cnt_q == 2'd3) begin
              if (n_full > 32'(SIZE)) begin
                state_d    = S_ERR;
                overflow_d = 1'b1;
              end else if (n_full == 32'd0) begin
                finish_load = 1'b1;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d[byte_pos +: 8] = rx_data;
            if (byte_cnt_q == 2'd3) begin
              state_d   = S_WRITE;
              wr_en_d   = 1'b1;
              wr_data_d = {rx_data, shift_q[23:0]};
              wr_addr_d = BASE_ADDR + (`WORD'(word_cnt_q) << 2);
            end
          end
        end

        S_WRITE: begin
          word_cnt_d = word_cnt_q + CW'(1);
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d = sum_q + wr_data_q;
`endif
          if ((32'(word_cnt_q) + 32'd1) < hdr_q) begin
            state_d = S_DATA;
          end else begin
            finish_load = 1'b1;
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            chk_d[byte_pos +: 8] = rx_data;
            if (byte_cnt_q == 2'd3) begin
              if (sum_q == {rx_data, chk_q[23:0]}) begin
                state_d    = S_DONE;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
              end else begin
                state_d   = S_ERR;
                chk_err_d = 1'b1;
              end
            end
          end
        end
`endif

        default: begin
        end
      endcase

      // End of the data stream: either verify the checksum or release the core.
      if (finish_load) begin
`ifdef INST_LOADER_CHECKSUM_EN
        state_d    = S_CHK;
        byte_cnt_d = 2'd0;
`else
        state_d    = S_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
`endif
      end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
`else
    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
`endif
  end

  // State and registered outputs; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      hdr_q      <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_q      <= hdr_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  // Running word sum, received checksum and mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      chk_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_q     <= chk_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign word_cnt = word_cnt_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: random images checked against a
// list-based model (word i lands at BASE + 4*i with the image word as data).
module tb_inst_loader;

  localparam int unsigned SIZE = 1024;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, wr_en, cpu_hold, done, overflow, chk_err;
  logic [31:0] wr_addr, wr_data;
  logic [10:0] word_cnt;

  inst_loader #(.SIZE(SIZE), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_cnt(word_cnt), .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit stall_tmo = 1'b0;
  logic [31:0] img[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  // Capture every write strobe mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    @(negedge clk);
    if (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      stall_tmo = 1'b1;
      rx_valid  = 1'b0;
    end else begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  // Sends header, all img words and (checksum build) the image checksum.
  task automatic send_image(input bit gap);
    logic [31:0] s;
    s = 32'd0;
    send_word(32'(img.size()), gap);
    foreach (img[i]) begin
      send_word(img[i], gap);
      s = s + img[i];
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_word(s, gap);
`endif
  endtask

  task automatic wait_done(output bit ok);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic make_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    n_checks++; if ({wr_addr, wr_data} !== 64'd0) begin n_fail++; $display("FAIL reset_wr_bus got %h/%h want 0", wr_addr, wr_data); end
    n_checks++; if (word_cnt !== 11'd0) begin n_fail++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
    n_checks++; if ({cpu_hold, done, overflow, chk_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {cpu_hold, done, overflow, chk_err}); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if ({rx_ready, cpu_hold} !== 2'b00) begin n_fail++; $display("FAIL idle_outputs got %b want 00", {rx_ready, cpu_hold}); end
  endtask

  task automatic test_two_word();
    bit ok;
    clear_cap();
    img.delete();
    img.push_back(32'hD280_0013);
    img.push_back(32'h1400_0000);
    pulse_start();
    n_checks++; if ({cpu_hold, rx_ready, done} !== 3'b110) begin n_fail++; $display("FAIL start_hdr got %b want 110", {cpu_hold, rx_ready, done}); end
    send_image(1'b0);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL two_word_done got %b want 1", done); end
    n_checks++; if (cap_addr.size() != 2) begin n_fail++; $display("FAIL two_word_nwrites got %0d want 2", cap_addr.size()); end
    else begin
      n_checks++; if ({cap_addr[0], cap_data[0]} !== {32'h0, 32'hD280_0013}) begin n_fail++; $display("FAIL two_word_w0 got %h:%h want 0:d2800013", cap_addr[0], cap_data[0]); end
      n_checks++; if ({cap_addr[1], cap_data[1]} !== {32'h4, 32'h1400_0000}) begin n_fail++; $display("FAIL two_word_w1 got %h:%h want 4:14000000", cap_addr[1], cap_data[1]); end
    end
    n_checks++; if (word_cnt !== 11'd2) begin n_fail++; $display("FAIL two_word_cnt got %0d want 2", word_cnt); end
    n_checks++; if ({cpu_hold, rx_ready, chk_err} !== 3'b000) begin n_fail++; $display("FAIL two_word_release got %b want 000", {cpu_hold, rx_ready, chk_err}); end
    pulse_start();
    n_checks++; if ({done, cpu_hold, word_cnt} !== {2'b01, 11'd0}) begin n_fail++; $display("FAIL restart_clears got done=%b hold=%b cnt=%0d want 0 1 0", done, cpu_hold, word_cnt); end
    send_word(32'd0, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_word(32'd0, 1'b0);
`endif
  endtask

  task automatic test_zero_words();
    clear_cap();
    pulse_start();
    send_word(32'd0, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_word(32'd0, 1'b0);
`endif
    n_checks++; if ({done, cpu_hold} !== 2'b10) begin n_fail++; $display("FAIL zero_done got done=%b hold=%b want 1 0", done, cpu_hold); end
    repeat (2) @(negedge clk);
    n_checks++; if (cap_addr.size() != 0) begin n_fail++; $display("FAIL zero_nwrites got %0d want 0", cap_addr.size()); end
    n_checks++; if (word_cnt !== 11'd0) begin n_fail++; $display("FAIL zero_cnt got %0d want 0", word_cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    bit saw_ready;
    clear_cap();
    pulse_start();
    send_word(32'(SIZE + 1), 1'b0);
    n_checks++; if ({overflow, cpu_hold, rx_ready, done} !== 4'b1100) begin n_fail++; $display("FAIL ovf_flags got %b want 1100", {overflow, cpu_hold, rx_ready, done}); end
    saw_ready = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (6) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) saw_ready = 1'b1;
    end
    rx_valid = 1'b0;
    n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got 1 want 0"); end
    n_checks++; if ({cap_addr.size() == 0, overflow, cpu_hold} !== 3'b111) begin n_fail++; $display("FAIL ovf_stuck got nw=%0d ovf=%b hold=%b want 0 1 1", cap_addr.size(), overflow, cpu_hold); end
    pulse_start();
    n_checks++; if ({overflow, cpu_hold} !== 2'b01) begin n_fail++; $display("FAIL ovf_clear got ovf=%b hold=%b want 0 1", overflow, cpu_hold); end
    make_img(3);
    send_image(1'b0);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_reload_done got %b want 1", done); end
    n_checks++; if (cap_data.size() != 3) begin n_fail++; $display("FAIL ovf_reload_n got %0d want 3", cap_data.size()); end
    else foreach (img[i]) begin
      n_checks++; if ({cap_addr[i], cap_data[i]} !== {BASE + 32'(4 * i), img[i]}) begin n_fail++; $display("FAIL ovf_reload_w%0d got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], BASE + 32'(4 * i), img[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] s;
    clear_cap();
    img.delete();
    img.push_back(32'hD280_0013);
    img.push_back(32'h1400_0000);
    pulse_start();
    send_word(32'd2, 1'b1);
    send_byte(8'h13, 1'b1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_byte(8'h00, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hD2, 1'b1);
    send_word(32'h1400_0000, 1'b1);
`ifdef INST_LOADER_CHECKSUM_EN
    s = 32'hD280_0013 + 32'h1400_0000;
    send_word(s, 1'b1);
`else
    s = 32'd0;
`endif
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done got %b want 1 (sum %h)", done, s); end
    n_checks++; if (cap_addr.size() != 2) begin n_fail++; $display("FAIL bp_nwrites got %0d want 2", cap_addr.size()); end
    else begin
      n_checks++; if ({cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]} !== {32'h0, 32'hD280_0013, 32'h4, 32'h1400_0000}) begin n_fail++; $display("FAIL bp_writes got %h:%h %h:%h", cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]); end
    end
    clear_cap();
    make_img(3);
    pulse_start();
    send_image(1'b0);
    wait_done(ok);
    n_checks++; if (!ok || word_cnt !== 11'd3) begin n_fail++; $display("FAIL b2b_done got done=%b cnt=%0d want 1 3", done, word_cnt); end
    n_checks++; if (cap_addr.size() != 3) begin n_fail++; $display("FAIL b2b_nwrites got %0d want 3", cap_addr.size()); end
    else foreach (img[i]) begin
      n_checks++; if ({cap_addr[i], cap_data[i]} !== {BASE + 32'(4 * i), img[i]}) begin n_fail++; $display("FAIL b2b_w%0d got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], BASE + 32'(4 * i), img[i]); end
    end
  endtask

  task automatic test_random_loads();
    bit ok;
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 12);
      make_img(n);
      clear_cap();
      pulse_start();
      send_image(bit'($urandom_range(0, 1)));
      wait_done(ok);
      n_checks++; if (!ok || word_cnt !== 11'(n)) begin n_fail++; $display("FAIL rand%0d_done got done=%b cnt=%0d want 1 %0d", it, done, word_cnt, n); end
      n_checks++; if (cap_addr.size() != n) begin n_fail++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, cap_addr.size(), n); end
      else foreach (img[i]) begin
        n_checks++; if ({cap_addr[i], cap_data[i]} !== {BASE + 32'(4 * i), img[i]}) begin n_fail++; $display("FAIL rand%0d_w%0d got %h:%h want %h:%h", it, i, cap_addr[i], cap_data[i], BASE + 32'(4 * i), img[i]); end
      end
    end
  endtask

  task automatic test_full_size();
    bit ok;
    int bad;
    make_img(SIZE);
    clear_cap();
    pulse_start();
    send_image(1'b0);
    wait_done(ok);
    n_checks++; if (!ok || overflow !== 1'b0) begin n_fail++; $display("FAIL full_done got done=%b ovf=%b want 1 0", done, overflow); end
    n_checks++; if (word_cnt !== 11'(SIZE)) begin n_fail++; $display("FAIL full_cnt got %0d want %0d", word_cnt, SIZE); end
    n_checks++; if (cap_addr.size() != SIZE) begin n_fail++; $display("FAIL full_nwrites got %0d want %0d", cap_addr.size(), SIZE); end
    else begin
      n_checks++; if (cap_addr[SIZE-1] !== BASE + 32'(4 * (SIZE - 1))) begin n_fail++; $display("FAIL full_last_addr got %h want %h", cap_addr[SIZE-1], BASE + 32'(4 * (SIZE - 1))); end
      bad = 0;
      foreach (img[i]) if ({cap_addr[i], cap_data[i]} !== {BASE + 32'(4 * i), img[i]}) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_words got %0d bad words want 0", bad); end
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    clear_cap();
    make_img(2);
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(img[0][7:0], 1'b0);
    send_byte(img[0][15:8], 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_checks++; if ({rx_ready, wr_en, cpu_hold, done, overflow, chk_err} !== 6'b0) begin n_fail++; $display("FAIL midrst_flags got %b want 000000", {rx_ready, wr_en, cpu_hold, done, overflow, chk_err}); end
    n_checks++; if ({wr_addr, wr_data, word_cnt} !== 75'd0) begin n_fail++; $display("FAIL midrst_bus got %h %h %0d want 0", wr_addr, wr_data, word_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (cap_addr.size() != 0) begin n_fail++; $display("FAIL midrst_nowrite got %0d want 0", cap_addr.size()); end
    make_img(1);
    pulse_start();
    send_image(1'b0);
    wait_done(ok);
    n_checks++; if (!ok || cap_addr.size() != 1) begin n_fail++; $display("FAIL midrst_reload got done=%b nw=%0d want 1 1", done, cap_addr.size()); end
    else begin
      n_checks++; if ({cap_addr[0], cap_data[0]} !== {BASE, img[0]}) begin n_fail++; $display("FAIL midrst_w0 got %h:%h want %h:%h", cap_addr[0], cap_data[0], BASE, img[0]); end
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    clear_cap();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'd5, 1'b0);
    send_word(32'd5, 1'b0);
    wait_done(ok);
    n_checks++; if (!ok || chk_err !== 1'b0) begin n_fail++; $display("FAIL chk_good got done=%b err=%b want 1 0", done, chk_err); end
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'd5, 1'b0);
    send_word(32'd6, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if ({chk_err, cpu_hold, done, rx_ready} !== 4'b1100) begin n_fail++; $display("FAIL chk_bad got %b want 1100", {chk_err, cpu_hold, done, rx_ready}); end
    n_checks++; if (cap_data.size() != 2 || cap_data[1] !== 32'd5) begin n_fail++; $display("FAIL chk_kept_write got n=%0d want 2", cap_data.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_word();
    test_zero_words();
    test_overflow();
    test_back_to_back();
    test_random_loads();
    test_reset_midload();
    test_full_size();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    n_checks++;
    if (stall_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_handshake got timeout want none");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side counterpart of the instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Issues one write per instruction into the instruction memory's write port, holding the CPU stalled (cpu_hold) until the program image is loaded.
- Sits between the host/UART byte source and the IF-stage instruction memory.

Parameters:
- SIZE, 1024: capacity of instruction memory in 32-bit words; image word count above SIZE is rejected.
- BASE_ADDR, 0: byte address of the first instruction written.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse to begin a load; honoured only in IDLE, DONE or ERR.
- rx_valid  in  1  byte source has a valid byte.
- rx_data  in  8  byte from source.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  `WORD  byte address of the write: BASE_ADDR + 4*index.
- wr_data  out  `INST_SIZE  assembled instruction.
- word_cnt  out  $clog2(SIZE)+1  words written in the current load.
- cpu_hold  out  1  stall/hold request to the core.
- done  out  1  load completed successfully; level, cleared by start.
- overflow  out  1  header count exceeded SIZE; level, cleared by start.
- chk_err  out  1  checksum mismatch; driven 0 when the checksum feature is compiled out.

Behaviour:
- Reset is asynchronous, active-low, with a single clock.
  - All outputs go to 0, state goes to IDLE, and the byte, word and header registers clear.
  - Reset mid-load abandons the load. Words already written stay in memory; no write is issued during or after reset.
- Image format: 4-byte header N (word count, LSB first), then N×4 instruction bytes, each word LSB first.
- States: IDLE, HDR, DATA, WRITE, (CHK), DONE, ERR.
- IDLE: rx_ready=0, cpu_hold=0.
  - On start: go to HDR; cpu_hold=1; clear done, overflow, chk_err and word_cnt.
- HDR: rx_ready=1. A 2-bit byte counter shifts each accepted byte into N at position 8*k. After the 4th byte, the next state is:
  - N > SIZE → ERR with overflow=1;
  - N == 0 → DONE (or CHK if enabled);
  - otherwise → DATA.
- DATA: rx_ready=1; bytes are packed into a 32-bit shift register. The cycle the 4th byte is accepted, go to WRITE.
- WRITE: exactly one cycle, with rx_ready=0, wr_en=1, wr_data=assembled word, wr_addr=BASE_ADDR + 4*word_cnt.
  - word_cnt increments at the end of the cycle.
  - Next state is DATA if word_cnt+1 < N, else DONE (or CHK).
  - Throughput: at most 4 bytes per 5 cycles.
- DONE: cpu_hold=0, done=1, rx_ready=0.
- ERR: cpu_hold stays 1, rx_ready=0, no writes. Exit only via start or reset.
- Handshake:
  - rx_valid low stalls the FSM with no timeout.
  - Bytes presented while rx_ready=0 are not consumed.
  - start while in HDR, DATA, WRITE or CHK is ignored.
- Outputs are registered. wr_addr and wr_data are only meaningful while wr_en=1 and hold their last value otherwise.
- The last word is at address BASE_ADDR + 4*(SIZE-1) when N == SIZE; no address wrap is possible.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word (or after the header when N=0), state CHK receives 4 more bytes, LSB first, forming checksum C.
  - The loader keeps a running sum S of all written words, mod 2^32.
  - If S==C → DONE. Otherwise → ERR with chk_err=1; cpu_hold stays 1 and already-written words are not undone.
- When undefined: no CHK state, chk_err is constant 0, and the stream ends after the data bytes.

Test Plan:
- Load 2 words: start, then bytes 02 00 00 00 | 13 00 80 D2 | 00 00 00 14 → two writes: addr 0x0 data 0xD2800013, addr 0x4 data 0x14000000; word_cnt=2; done=1; cpu_hold=0.
- N=0: header 00 00 00 00 → no wr_en, done=1 one cycle after the 4th header byte (checksum off).
- Overflow: SIZE=1024, header 01 04 00 00 (N=1025) → overflow=1, cpu_hold=1, no wr_en, rx_ready=0. A following start clears overflow and reloads.
- Back-pressure: the 2-word load with rx_valid toggled every other cycle and start pulsed during DATA → identical writes, start ignored.
- Reset mid-load: assert rst_n=0 after the 2nd data byte → all outputs 0 and state IDLE immediately. A fresh load then writes word 0 at BASE_ADDR.
- Checksum on: 1 word 0x00000005 followed by checksum 05 00 00 00 → done=1. Checksum 06 00 00 00 → chk_err=1 and cpu_hold=1.
